motion_segment_controller: RTL and testbench
============================================

Name: motion_segment_controller

Overview:
- Accepts one linear move segment: signed step deltas for X, Y, Z and E0 plus a tick period.
- Generates coordinated step, direction and enable signals for the four stepper drivers using Bresenham interpolation on the major axis.
- The same signals feed the drivers and the position-tracking block, so the tracked position must end at start + delta for every axis.
- Sits between the command/FIFO logic and the stepper outputs; one segment is in flight at a time.

Parameters:
PULSE_WIDTH, 4, step high time in clk cycles (>=1)
DIR_SETUP, 8, cycles between direction update and first step edge (>=1)
IDLE_TIMEOUT, 1000000, idle cycles before motors are disabled (AUTO_DISABLE_EN only)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous reset, active-low
cmd_valid  in  1  segment command valid
cmd_ready  out  1  controller can accept a command
cmd_dx, cmd_dy, cmd_dz, cmd_de0  in  32 each  signed step deltas
cmd_period  in  16  clk cycles per major-axis tick
abort  in  1  stop segment at next tick boundary
stepper_x_inversion, stepper_y_inversion, stepper_z_inversion, stepper_e0_inversion  in  1 each  axis direction inversion
stepper_x_step, stepper_y_step, stepper_z_step, stepper_e0_step  out  1 each  step pulses (rising edge = step)
stepper_x_direction, stepper_y_direction, stepper_z_direction, stepper_e0_direction  out  1 each  driver direction
stepper_x_enable, stepper_y_enable, stepper_z_enable, stepper_e0_enable  out  1 each  driver enable, active-low
busy  out  1  segment in progress
done  out  1  one-cycle pulse when a segment ends
aborted  out  1  set with done if the segment ended by abort; holds until next accept
ticks_left  out  32  major-axis ticks remaining

Behaviour:
- Reset (reset_n low at a clk edge), any state: state=IDLE; all step=0, direction=0, enable=1; cmd_ready=1; busy=0; done=0; aborted=0; ticks_left=0; accumulators=0.
- Reset mid-segment: step drops on the same edge and the segment is discarded.
- Accept: handshake completes when cmd_valid && cmd_ready at edge T. The controller latches |d| per axis, major = max |d|, and eff_period = max(cmd_period, 2*PULSE_WIDTH).
- Width rule: |d| is computed on 32 bits; -2^31 saturates to 2^31-1.
- From T+1:
  - direction_a = (d_a < 0) XOR stepper_a_inversion.
  - All enables = 0.
  - cmd_ready=0, busy=1, ticks_left=major.
  - acc_a = major>>1 for every axis.
- States:
  - IDLE: cmd_ready=1. Accept -> SETUP.
  - SETUP: lasts DIR_SETUP cycles. Then -> DONE if major==0, else -> STEP_HI.
  - STEP_HI: on entry, for each axis acc_a += |d_a|; if acc_a >= major, assert step_a and acc_a -= major. Step high lasts exactly PULSE_WIDTH cycles. ticks_left decrements on entry. Then -> STEP_LO.
  - STEP_LO: all steps 0 for eff_period-PULSE_WIDTH cycles. At the end, -> DONE if ticks_left==0 or abort is latched, else -> STEP_HI.
  - DONE: one cycle; done=1, busy=0. Next cycle -> IDLE with cmd_ready=1.
- Timing:
  - First step rising edge is at T+1+DIR_SETUP.
  - Consecutive ticks are exactly eff_period cycles apart.
  - The major axis steps every tick; each axis emits exactly |d_a| pulses.
- Abort:
  - Latched on any cycle while busy.
  - A pulse already high completes its full PULSE_WIDTH and the low phase completes.
  - No further STEP_HI is entered; DONE follows with aborted=1.
  - Abort in SETUP: DONE after SETUP with zero steps, aborted=1.
  - Abort in IDLE is ignored.
- Direction lines do not change while busy. Inversion inputs are sampled only at accept.
- Enables stay 0 after the first accept; release is governed only by the optional feature.

Optional Feature:
- Macro: MOTION_AUTO_DISABLE_EN.
- Defined: a counter runs in IDLE and clears on accept. When it reaches IDLE_TIMEOUT, all enables go to 1. The next accept re-enables them at T+1, and SETUP still guarantees DIR_SETUP cycles before the first step.
- Undefined: the counter is absent; enables stay 0 from the first accept until reset.

Test Plan:
1. PULSE_WIDTH=2, DIR_SETUP=8, dx=4, dy=2, period=10, accept at cycle 0 -> x steps rise at cycles 9, 19, 29, 39; y steps rise at 9 and 29; each pulse high 2 cycles; done at cycle 49; aborted=0.
2. dx=-3, stepper_x_inversion=1 -> stepper_x_direction=0 from cycle 1; 3 x pulses; y, z and e0 produce none.
3. All deltas 0 -> no step pulses; done at cycle 1+DIR_SETUP; cmd_ready returns high the following cycle.
4. dz=100, period=10, abort pulsed at cycle 25 -> z pulses at 9 and 19 only; done at cycle 29; aborted=1.
5. period=1, PULSE_WIDTH=4, de0=3 -> eff_period=8; pulses 8 cycles apart, each high 4 cycles.
6. reset_n low mid STEP_HI -> step=0, enable=1, cmd_ready=1 on the next edge. With MOTION_AUTO_DISABLE_EN and IDLE_TIMEOUT=50: enables go to 1 exactly 50 idle cycles after DONE.

Source files
------------

// File: rtl/motion_segment_controller.sv
// Four-axis linear segment generator: Bresenham step/dir/enable sequencing per segment.
// Optional idle motor release is built when MOTION_AUTO_DISABLE_EN is defined.
module motion_segment_controller #(
    parameter int unsigned PULSE_WIDTH  = 4,
    parameter int unsigned DIR_SETUP    = 8
`ifdef MOTION_AUTO_DISABLE_EN
    ,
    parameter int unsigned IDLE_TIMEOUT = 1000000
`endif
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_dx,
    input  logic [31:0] cmd_dy,
    input  logic [31:0] cmd_dz,
    input  logic [31:0] cmd_de0,
    input  logic [15:0] cmd_period,
    input  logic        abort,
    input  logic        stepper_x_inversion,
    input  logic        stepper_y_inversion,
    input  logic        stepper_z_inversion,
    input  logic        stepper_e0_inversion,
    output logic        stepper_x_step,
    output logic        stepper_y_step,
    output logic        stepper_z_step,
    output logic        stepper_e0_step,
    output logic        stepper_x_direction,
    output logic        stepper_y_direction,
    output logic        stepper_z_direction,
    output logic        stepper_e0_direction,
    output logic        stepper_x_enable,
    output logic        stepper_y_enable,
    output logic        stepper_z_enable,
    output logic        stepper_e0_enable,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic [31:0] ticks_left
);

    localparam logic [31:0] MIN_PERIOD = 32'(2 * PULSE_WIDTH);
    localparam logic [31:0] PW_CYCLES  = 32'(PULSE_WIDTH);
    localparam logic [31:0] DS_CYCLES  = 32'(DIR_SETUP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STEP_HI,
        S_STEP_LO,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] major_q, major_d;
    logic [31:0] eff_period_q, eff_period_d;
    logic [31:0] ticks_left_q, ticks_left_d;
    logic [31:0] mag_q [4];
    logic [31:0] mag_d [4];
    logic [31:0] acc_q [4];
    logic [31:0] acc_d [4];
    logic [3:0]  step_q, step_d;
    logic [3:0]  dir_q, dir_d;
    logic        en_n_q, en_n_d;
    logic        abort_q, abort_d;
    logic        aborted_q, aborted_d;

    logic [31:0] cmd_d [4];
    logic [31:0] mag_in [4];
    logic [32:0] acc_sum [4];
    logic [3:0]  inv_in;
    logic [31:0] major_in;
    logic [31:0] eff_period_in;
    logic        busy_w;
    logic        abort_seen;
    logic        tick_start;
    logic        auto_off;

    // -2^31 has no positive 32-bit counterpart, so it saturates.
    function automatic logic [31:0] abs_sat(input logic [31:0] d);
        if (d == 32'h8000_0000) begin
            return 32'h7FFF_FFFF;
        end else if (d[31]) begin
            return 32'(-d);
        end else begin
            return d;
        end
    endfunction

`ifdef MOTION_AUTO_DISABLE_EN
    logic [31:0] idle_cnt_q, idle_cnt_d;

    always_comb begin
        idle_cnt_d = '0;
        if (state_q == S_DONE || (state_q == S_IDLE && !cmd_valid)) begin
            idle_cnt_d = (idle_cnt_q == IDLE_TIMEOUT) ? idle_cnt_q : idle_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign auto_off = (idle_cnt_d == IDLE_TIMEOUT);
`else
    assign auto_off = 1'b0;
`endif

    always_comb begin
        cmd_d[0] = cmd_dx;
        cmd_d[1] = cmd_dy;
        cmd_d[2] = cmd_dz;
        cmd_d[3] = cmd_de0;
        inv_in   = {stepper_e0_inversion, stepper_z_inversion,
                    stepper_y_inversion, stepper_x_inversion};
        major_in = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            mag_in[i]  = abs_sat(cmd_d[i]);
            acc_sum[i] = {1'b0, acc_q[i]} + {1'b0, mag_q[i]};
            if (mag_in[i] > major_in) begin
                major_in = mag_in[i];
            end
        end
        eff_period_in = ({16'd0, cmd_period} > MIN_PERIOD) ? {16'd0, cmd_period} : MIN_PERIOD;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        major_d      = major_q;
        eff_period_d = eff_period_q;
        ticks_left_d = ticks_left_q;
        step_d       = step_q;
        dir_d        = dir_q;
        en_n_d       = en_n_q;
        abort_d      = abort_q;
        aborted_d    = aborted_q;
        for (int unsigned i = 0; i < 4; i++) begin
            mag_d[i] = mag_q[i];
            acc_d[i] = acc_q[i];
        end
        tick_start = 1'b0;
        busy_w     = (state_q != S_IDLE) && (state_q != S_DONE);
        abort_seen = abort_q | (abort & busy_w);

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d      = S_SETUP;
                    cnt_d        = DS_CYCLES - 32'd1;
                    major_d      = major_in;
                    eff_period_d = eff_period_in;
                    ticks_left_d = major_in;
                    en_n_d       = 1'b0;
                    abort_d      = 1'b0;
                    aborted_d    = 1'b0;
                    for (int unsigned i = 0; i < 4; i++) begin
                        mag_d[i] = mag_in[i];
                        acc_d[i] = major_in >> 1;
                        dir_d[i] = cmd_d[i][31] ^ inv_in[i];
                    end
                end
            end
            S_SETUP: begin
                abort_d = abort_seen;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 32'd1;
                end else if (major_q == '0 || abort_seen) begin
                    state_d   = S_DONE;
                    aborted_d = abort_seen && (major_q != '0);
                end else begin
                    tick_start = 1'b1;
                end
            end
            S_STEP_HI: begin
                abort_d = abort_seen;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 32'd1;
                end else begin
                    state_d = S_STEP_LO;
                    step_d  = '0;
                    cnt_d   = eff_period_q - PW_CYCLES - 32'd1;
                end
            end
            S_STEP_LO: begin
                abort_d = abort_seen;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 32'd1;
                end else if (ticks_left_q == '0 || abort_seen) begin
                    state_d   = S_DONE;
                    aborted_d = abort_seen && (ticks_left_q != '0);
                end else begin
                    tick_start = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Accumulator update happens on the edge that enters STEP_HI so step rises with it.
        if (tick_start) begin
            state_d      = S_STEP_HI;
            cnt_d        = PW_CYCLES - 32'd1;
            ticks_left_d = ticks_left_q - 32'd1;
            for (int unsigned i = 0; i < 4; i++) begin
                if (acc_sum[i] >= {1'b0, major_q}) begin
                    step_d[i] = 1'b1;
                    acc_d[i]  = 32'(acc_sum[i] - {1'b0, major_q});
                end else begin
                    step_d[i] = 1'b0;
                    acc_d[i]  = acc_sum[i][31:0];
                end
            end
        end

        if (auto_off) begin
            en_n_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            major_q      <= '0;
            eff_period_q <= '0;
            ticks_left_q <= '0;
            step_q       <= '0;
            dir_q        <= '0;
            en_n_q       <= 1'b1;
            abort_q      <= 1'b0;
            aborted_q    <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                mag_q[i] <= '0;
                acc_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            major_q      <= major_d;
            eff_period_q <= eff_period_d;
            ticks_left_q <= ticks_left_d;
            step_q       <= step_d;
            dir_q        <= dir_d;
            en_n_q       <= en_n_d;
            abort_q      <= abort_d;
            aborted_q    <= aborted_d;
            for (int unsigned i = 0; i < 4; i++) begin
                mag_q[i] <= mag_d[i];
                acc_q[i] <= acc_d[i];
            end
        end
    end

    assign cmd_ready            = (state_q == S_IDLE);
    assign busy                 = busy_w;
    assign done                 = (state_q == S_DONE);
    assign aborted              = aborted_q;
    assign ticks_left           = ticks_left_q;
    assign stepper_x_step       = step_q[0];
    assign stepper_y_step       = step_q[1];
    assign stepper_z_step       = step_q[2];
    assign stepper_e0_step      = step_q[3];
    assign stepper_x_direction  = dir_q[0];
    assign stepper_y_direction  = dir_q[1];
    assign stepper_z_direction  = dir_q[2];
    assign stepper_e0_direction = dir_q[3];
    assign stepper_x_enable     = en_n_q;
    assign stepper_y_enable     = en_n_q;
    assign stepper_z_enable     = en_n_q;
    assign stepper_e0_enable    = en_n_q;

endmodule

// File: tb/tb_motion_segment_controller.sv
// Randomized bench for motion_segment_controller against a closed-form tick/pulse reference model.
module tb_motion_segment_controller;

    localparam int PW = 2;
    localparam int DS = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_dx, cmd_dy, cmd_dz, cmd_de0;
    logic [15:0] cmd_period;
    logic        abort;
    logic        x_inv, y_inv, z_inv, e0_inv;
    logic        x_step, y_step, z_step, e0_step;
    logic        x_dir, y_dir, z_dir, e0_dir;
    logic        x_en, y_en, z_en, e0_en;
    logic        busy, done, aborted;
    logic [31:0] ticks_left;

    logic [3:0] step_v, dir_v, en_v;
    assign step_v = {e0_step, z_step, y_step, x_step};
    assign dir_v  = {e0_dir, z_dir, y_dir, x_dir};
    assign en_v   = {e0_en, z_en, y_en, x_en};

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    motion_segment_controller #(.PULSE_WIDTH(PW), .DIR_SETUP(DS)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dx(cmd_dx), .cmd_dy(cmd_dy), .cmd_dz(cmd_dz), .cmd_de0(cmd_de0),
        .cmd_period(cmd_period), .abort(abort),
        .stepper_x_inversion(x_inv), .stepper_y_inversion(y_inv),
        .stepper_z_inversion(z_inv), .stepper_e0_inversion(e0_inv),
        .stepper_x_step(x_step), .stepper_y_step(y_step),
        .stepper_z_step(z_step), .stepper_e0_step(e0_step),
        .stepper_x_direction(x_dir), .stepper_y_direction(y_dir),
        .stepper_z_direction(z_dir), .stepper_e0_direction(e0_dir),
        .stepper_x_enable(x_en), .stepper_y_enable(y_en),
        .stepper_z_enable(z_en), .stepper_e0_enable(e0_en),
        .busy(busy), .done(done), .aborted(aborted), .ticks_left(ticks_left)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_wait", cmd_ready, 1);
    endtask

    // Cycle numbering: the accept edge ends cycle 0; values seen after it belong to cycle 1.
    task automatic run_seg(input int d0, input int d1, input int d2, input int d3,
                           input logic [3:0] inv, input int per, input int abort_cyc);
        longint mag[4], major, eff, first, n_run, done_exp, h;
        longint exp_r[4][128], got_r[4][128];
        int     ne[4], nr[4], hi[4];
        int     d[4];
        logic [3:0] dir_exp, prev;
        int     dir_err, en_err, done_cyc, budget;

        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        major = 0;
        for (int a = 0; a < 4; a++) begin
            mag[a]     = (d[a] < 0) ? -longint'(d[a]) : longint'(d[a]);
            dir_exp[a] = (d[a] < 0) ^ inv[a];
            if (mag[a] > major) major = mag[a];
            ne[a] = 0; nr[a] = 0; hi[a] = 0;
        end
        eff   = (per > 2 * PW) ? per : 2 * PW;
        first = 1 + DS;
        h     = major / 2;
        if (abort_cyc <= 0)        n_run = major;
        else if (abort_cyc < first) n_run = 0;
        else begin
            n_run = (abort_cyc - first) / eff + 1;
            if (n_run > major) n_run = major;
        end
        done_exp = first + n_run * eff;
        for (longint k = 1; k <= n_run; k++) begin
            for (int a = 0; a < 4; a++) begin
                if ((h + k * mag[a]) / major != (h + (k - 1) * mag[a]) / major) begin
                    if (ne[a] < 128) exp_r[a][ne[a]] = first + (k - 1) * eff;
                    ne[a]++;
                end
            end
        end

        wait_ready();
        cmd_dx = d0; cmd_dy = d1; cmd_dz = d2; cmd_de0 = d3;
        cmd_period = 16'(per);
        {e0_inv, z_inv, y_inv, x_inv} = inv;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_dx = $urandom; cmd_dy = $urandom; cmd_dz = $urandom; cmd_de0 = $urandom;
        cmd_period = 16'($urandom);
        {e0_inv, z_inv, y_inv, x_inv} = 4'($urandom);

        prev = '0; dir_err = 0; en_err = 0; done_cyc = -1;
        budget = int'(done_exp) + 50;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            if (cyc == 1) begin
                check("ticks_c1", ticks_left, major);
                check("busy_c1", busy, 1);
                check("ready_c1", cmd_ready, 0);
                check("dir_c1", dir_v, dir_exp);
                check("en_c1", en_v, 0);
            end
            if (busy && dir_v != dir_exp) dir_err++;
            if (busy && en_v != 4'h0) en_err++;
            for (int a = 0; a < 4; a++) begin
                if (step_v[a]) hi[a]++;
                if (step_v[a] && !prev[a]) begin
                    if (nr[a] < 128) got_r[a][nr[a]] = cyc;
                    nr[a]++;
                end
            end
            prev = step_v;
            if (done) begin
                done_cyc = cyc;
                check("done_busy", busy, 0);
                check("done_aborted", aborted, (n_run < major) ? 1 : 0);
                check("done_ticks", ticks_left, major - n_run);
                break;
            end
            abort = (cyc == abort_cyc);
            @(posedge clk); #1;
        end
        abort = 1'b0;
        check("done_cycle", done_cyc, done_exp);
        check("dir_stable", dir_err, 0);
        check("en_low", en_err, 0);
        @(posedge clk); #1;
        check("ready_after", cmd_ready, 1);
        check("done_pulse", done, 0);
        check("aborted_hold", aborted, (n_run < major) ? 1 : 0);
        check("en_after", en_v, 0);
        for (int a = 0; a < 4; a++) begin
            check($sformatf("pulses_%0d", a), nr[a], ne[a]);
            check($sformatf("high_%0d", a), hi[a], ne[a] * PW);
            for (int k = 0; k < ne[a] && k < nr[a] && k < 128; k++)
                check($sformatf("rise_%0d_%0d", a, k), got_r[a][k], exp_r[a][k]);
        end
    endtask

    initial begin
        int r[4];
        int per, ab;
        longint maj, effp;

        reset_n = 1'b0; cmd_valid = 1'b0; abort = 1'b0;
        cmd_dx = '0; cmd_dy = '0; cmd_dz = '0; cmd_de0 = '0; cmd_period = '0;
        {e0_inv, z_inv, y_inv, x_inv} = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_step", step_v, 0);
        check("rst_dir", dir_v, 0);
        check("rst_en", en_v, 4'hF);
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_aborted", aborted, 0);
        check("rst_ticks", ticks_left, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_seg(4, 2, 0, 0, 4'b0000, 10, 0);
        run_seg(-3, 0, 0, 0, 4'b0001, 10, 0);
        run_seg(0, 0, 0, 0, 4'b0000, 10, 0);
        run_seg(0, 0, 100, 0, 4'b0000, 10, 25);
        run_seg(0, 0, 0, 3, 4'b0000, 1, 0);
        run_seg(5, -7, 2, 0, 4'b0110, 12, 4);

        // Saturating magnitude, then reset while a step pulse is high.
        wait_ready();
        cmd_dx = 32'h8000_0000; cmd_dy = '0; cmd_dz = '0; cmd_de0 = '0;
        cmd_period = 16'd10; {e0_inv, z_inv, y_inv, x_inv} = '0;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("sat_ticks", ticks_left, 32'h7FFF_FFFF);
        check("sat_dir", x_dir, 1);
        repeat (DS) @(posedge clk);
        #1;
        check("sat_step", x_step, 1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_step", step_v, 0);
        check("mid_rst_en", en_v, 4'hF);
        check("mid_rst_ready", cmd_ready, 1);
        check("mid_rst_busy", busy, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int s = 0; s < 25; s++) begin
            maj = 0;
            for (int a = 0; a < 4; a++) begin
                r[a] = int'($urandom_range(0, 40)) - 20;
                if ($urandom_range(0, 3) == 0) r[a] = 0;
                if ((r[a] < 0 ? -r[a] : r[a]) > maj) maj = (r[a] < 0 ? -r[a] : r[a]);
            end
            per  = int'($urandom_range(0, 20));
            effp = (per > 2 * PW) ? per : 2 * PW;
            ab   = 0;
            if ($urandom_range(0, 3) == 0) ab = int'($urandom_range(1, 1 + DS + int'(maj * effp)));
            run_seg(r[0], r[1], r[2], r[3], 4'($urandom), per, ab);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
